// File: rtl/rv_alu_chunked_fsm.sv
// Multicycle ALU: processes XLEN-bit operands CHUNK_W bits per cycle with a ripple carry.
// Optional macro ALU_FAST_LOGIC_EN lets AND/OR/XOR bypass the chunked EXEC phase.
`timescale 1ns / 1ps

module rv_alu_chunked_fsm #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CHUNK_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [XLEN-1:0]   i_operand_one,
    input  logic [XLEN-1:0]   i_operand_two,
    input  logic [2:0]        i_alu_sel,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   o_result,
    output logic              o_carry_out,
    output logic              o_illegal
);

    localparam int unsigned NCHUNK = XLEN / CHUNK_W;
    localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpOr   = 3'b011,
        OpXor  = 3'b100,
        OpSlt  = 3'b101,
        OpSltu = 3'b110,
        OpIll  = 3'b111
    } alu_op_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    alu_op_e             op_q, op_d;
    logic                carry_q, carry_d;
    logic [XLEN-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                carry_out_q, carry_out_d;
    logic                illegal_q, illegal_d;

    logic                in_idle, accept, is_sub_type, is_last, fast_path;
    alu_op_e             cur_op;
    logic [CHUNK_W-1:0]  cur_a, cur_b, b_eff, chunk_res;
    logic                cur_cin;
    logic [CHUNK_W:0]    sum;
    logic                flag_n, flag_v, flag_c;
    logic [XLEN-1:0]     acc_next, final_result, fast_result;
    logic                final_carry;

    assign in_idle     = (state_q == StIdle);
    assign o_req_ready = in_idle & ~i_flush;
    assign accept      = i_req_valid & o_req_ready;
    assign o_rsp_valid = (state_q == StDone);
    assign o_result    = result_q;
    assign o_carry_out = carry_out_q;
    assign o_illegal   = illegal_q;

    // Chunk 0 is taken straight from the request inputs on the accept edge, so the
    // datapath source switches between live inputs (IDLE) and captured operands (EXEC).
    always_comb begin
        cur_op      = in_idle ? alu_op_e'(i_alu_sel) : op_q;
        cur_a       = in_idle ? i_operand_one[CHUNK_W-1:0] : a_q[CHUNK_W-1:0];
        cur_b       = in_idle ? i_operand_two[CHUNK_W-1:0] : b_q[CHUNK_W-1:0];
        is_sub_type = (cur_op == OpSub) || (cur_op == OpSlt) || (cur_op == OpSltu);
        cur_cin     = in_idle ? is_sub_type : carry_q;
        b_eff       = is_sub_type ? ~cur_b : cur_b;
        sum         = {1'b0, cur_a} + {1'b0, b_eff} + {{CHUNK_W{1'b0}}, cur_cin};
        flag_n      = sum[CHUNK_W-1];
        flag_c      = sum[CHUNK_W];
        flag_v      = (cur_a[CHUNK_W-1] == b_eff[CHUNK_W-1]) & (flag_n != cur_a[CHUNK_W-1]);
        is_last     = in_idle ? (NCHUNK == 1) : (cnt_q == LastCnt);

        case (cur_op)
            OpAnd:   chunk_res = cur_a & cur_b;
            OpOr:    chunk_res = cur_a | cur_b;
            OpXor:   chunk_res = cur_a ^ cur_b;
            OpIll:   chunk_res = '0;
            default: chunk_res = sum[CHUNK_W-1:0];
        endcase

        // Result bits shift in from the top; after NCHUNK chunks the word is aligned.
        acc_next = acc_q >> CHUNK_W;
        acc_next[XLEN-1 -: CHUNK_W] = chunk_res;

        case (cur_op)
            OpSlt:   final_result = {{(XLEN-1){1'b0}}, flag_n ^ flag_v};
            OpSltu:  final_result = {{(XLEN-1){1'b0}}, ~flag_c};
            default: final_result = acc_next;
        endcase
        final_carry = (cur_op == OpAdd) | is_sub_type ? flag_c : 1'b0;

`ifdef ALU_FAST_LOGIC_EN
        fast_path = (cur_op == OpAnd) || (cur_op == OpOr) || (cur_op == OpXor) ||
                    (cur_op == OpIll);
        case (cur_op)
            OpAnd:   fast_result = i_operand_one & i_operand_two;
            OpOr:    fast_result = i_operand_one | i_operand_two;
            OpXor:   fast_result = i_operand_one ^ i_operand_two;
            default: fast_result = '0;
        endcase
`else
        fast_path   = (cur_op == OpIll);
        fast_result = '0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        illegal_d   = illegal_q;

        // Flush wins over everything and leaves the last response values untouched.
        if (i_flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_d    = cur_op;
                        a_d     = i_operand_one >> CHUNK_W;
                        b_d     = i_operand_two >> CHUNK_W;
                        carry_d = flag_c;
                        acc_d   = acc_next;
                        cnt_d   = CntW'(1);
                        if (fast_path) begin
                            state_d     = StDone;
                            cnt_d       = '0;
                            result_d    = fast_result;
                            carry_out_d = 1'b0;
                            illegal_d   = (cur_op == OpIll);
                        end else if (is_last) begin
                            state_d     = StDone;
                            cnt_d       = '0;
                            result_d    = final_result;
                            carry_out_d = final_carry;
                            illegal_d   = 1'b0;
                        end else begin
                            state_d = StExec;
                        end
                    end
                end
                StExec: begin
                    a_d     = a_q >> CHUNK_W;
                    b_d     = b_q >> CHUNK_W;
                    carry_d = flag_c;
                    acc_d   = acc_next;
                    cnt_d   = cnt_q + CntW'(1);
                    if (is_last) begin
                        state_d     = StDone;
                        cnt_d       = '0;
                        result_d    = final_result;
                        carry_out_d = final_carry;
                        illegal_d   = 1'b0;
                    end
                end
                StDone: begin
                    if (i_rsp_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OpAdd;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            illegal_q   <= illegal_d;
        end
    end

endmodule

// File: tb/tb_rv_alu_chunked_fsm.sv
// Directed bench for rv_alu_chunked_fsm: 32/8 instance plus a 64/16 instance.
`timescale 1ns / 1ps

module tb_rv_alu_chunked_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] op_a = '0, op_b = '0;
    logic [2:0]  sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out, illegal;

    logic        w_flush = 1'b0;
    logic        w_req_valid = 1'b0;
    logic        w_req_ready;
    logic [63:0] w_a = '0, w_b = '0;
    logic [2:0]  w_sel = '0;
    logic        w_rsp_valid;
    logic        w_rsp_ready = 1'b0;
    logic [63:0] w_result;
    logic        w_carry_out, w_illegal;

    int vectors = 0;
    int miscompares = 0;

`ifdef ALU_FAST_LOGIC_EN
    localparam int LogicLat = 1;
`else
    localparam int LogicLat = 4;
`endif

    always #5 clk = ~clk;

    rv_alu_chunked_fsm #(.XLEN(32), .CHUNK_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_req_valid(req_valid),
        .o_req_ready(req_ready), .i_operand_one(op_a), .i_operand_two(op_b),
        .i_alu_sel(sel), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_result(result), .o_carry_out(carry_out), .o_illegal(illegal)
    );

    rv_alu_chunked_fsm #(.XLEN(64), .CHUNK_W(16)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(w_flush), .i_req_valid(w_req_valid),
        .o_req_ready(w_req_ready), .i_operand_one(w_a), .i_operand_two(w_b),
        .i_alu_sel(w_sel), .o_rsp_valid(w_rsp_valid), .i_rsp_ready(w_rsp_ready),
        .o_result(w_result), .o_carry_out(w_carry_out), .o_illegal(w_illegal)
    );

    // Accept one request, scramble the inputs, and count cycles until rsp_valid (1 = next cycle).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        sel = op; op_a = a; op_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; op_a = ~a; op_b = ~b; sel = ~op;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        vectors++;
        if ({rsp_valid, result, carry_out, illegal} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b r=%h c=%b i=%b, want all 0",
                     rsp_valid, result, carry_out, illegal);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got ready=%b valid=%b, want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_add_wrap();
        int lat;
        rsp_ready = 1'b1;
        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        vectors++;
        if (lat !== 4) begin
            miscompares++; $display("FAIL add_latency: got %0d want 4", lat);
        end
        vectors++;
        if (result !== 32'h0 || carry_out !== 1'b1 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL add_wrap: got r=%h c=%b i=%b want 00000000/1/0", result, carry_out, illegal);
        end
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++; $display("FAIL add_ready_in_done: got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_ready_after_hs: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_sub_slt();
        int lat;
        issue(3'b001, 32'd5, 32'd7, lat);
        vectors++;
        if (lat !== 4 || result !== 32'hFFFF_FFFE || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL sub: got lat=%0d r=%h c=%b want 4/fffffffe/0", lat, result, carry_out);
        end
        finish_rsp();
        issue(3'b101, 32'h8000_0000, 32'h0000_0001, lat);
        vectors++;
        if (lat !== 4 || result !== 32'h1 || carry_out !== 1'b1) begin
            miscompares++;
            $display("FAIL slt: got lat=%0d r=%h c=%b want 4/00000001/1", lat, result, carry_out);
        end
        finish_rsp();
        issue(3'b110, 32'h8000_0000, 32'h0000_0001, lat);
        vectors++;
        if (lat !== 4 || result !== 32'h0 || carry_out !== 1'b1) begin
            miscompares++;
            $display("FAIL sltu: got lat=%0d r=%h c=%b want 4/00000000/1", lat, result, carry_out);
        end
        finish_rsp();
        issue(3'b110, 32'h0000_0003, 32'h8000_0000, lat);
        vectors++;
        if (result !== 32'h1 || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL sltu_lt: got r=%h c=%b want 00000001/0", result, carry_out);
        end
        finish_rsp();
    endtask

    task automatic test_logic();
        int lat;
        issue(3'b100, 32'hA5A5_A5A5, 32'hFFFF_0000, lat);
        vectors++;
        if (lat !== LogicLat || result !== 32'h5A5A_A5A5 || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL xor: got lat=%0d r=%h c=%b want %0d/5a5aa5a5/0",
                     lat, result, carry_out, LogicLat);
        end
        finish_rsp();
        issue(3'b011, 32'h1234_0000, 32'h0000_5678, lat);
        vectors++;
        if (lat !== LogicLat || result !== 32'h1234_5678 || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL or: got lat=%0d r=%h c=%b want %0d/12345678/0",
                     lat, result, carry_out, LogicLat);
        end
        finish_rsp();
    endtask

    task automatic test_hold();
        int lat;
        issue(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || result !== 32'hF000_F000 ||
                carry_out !== 1'b0 || illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b r=%h c=%b i=%b want 1/0/f000f000/0/0",
                         i, rsp_valid, req_ready, result, carry_out, illegal);
            end
            @(posedge clk); #1;
        end
        finish_rsp();
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || result !== 32'hF000_F000) begin
            miscompares++;
            $display("FAIL hold_release: got v=%b rdy=%b r=%h want 0/1/f000f000",
                     rsp_valid, req_ready, result);
        end
    endtask

    task automatic test_flush();
        int lat;
        int seen = 0;
        sel = 3'b000; op_a = 32'h1111_1111; op_b = 32'h2222_2222; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 0 || req_ready !== 1'b1 || result !== 32'hF000_F000) begin
            miscompares++;
            $display("FAIL flush_exec: got valid_cycles=%0d rdy=%b r=%h want 0/1/f000f000",
                     seen, req_ready, result);
        end
        issue(3'b000, 32'd3, 32'd4, lat);
        vectors++;
        if (lat !== 4 || result !== 32'd7 || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL add_after_flush: got lat=%0d r=%h c=%b want 4/00000007/0",
                     lat, result, carry_out);
        end
        finish_rsp();
        req_valid = 1'b1; flush = 1'b1; sel = 3'b111;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_idle_ready: got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_accept: got valid_cycles=%0d i=%b want 0/0", seen, illegal);
        end
    endtask

    task automatic test_illegal_reset();
        int lat;
        issue(3'b111, 32'hDEAD_BEEF, 32'h1234_5678, lat);
        vectors++;
        if (lat !== 1 || illegal !== 1'b1 || result !== 32'h0 || carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal: got lat=%0d i=%b r=%h c=%b want 1/1/00000000/0",
                     lat, illegal, result, carry_out);
        end
        finish_rsp();
        issue(3'b001, 32'd9, 32'd2, lat);
        vectors++;
        if (result !== 32'd7 || carry_out !== 1'b1 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_pre_reset: got r=%h c=%b i=%b want 00000007/1/0",
                     result, carry_out, illegal);
        end
        finish_rsp();
        sel = 3'b000; op_a = 32'hFFFF_FFFF; op_b = 32'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, result, carry_out, illegal} !== 35'd0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b r=%h c=%b i=%b rdy=%b want 0/0/0/0/1",
                     rsp_valid, result, carry_out, illegal, req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_lost_rsp: got v=%b r=%h want 0/00000000", rsp_valid, result);
        end
    endtask

    task automatic test_wide();
        int lat = 1;
        w_rsp_ready = 1'b1;
        w_sel = 3'b000; w_a = 64'hFFFF_FFFF_FFFF_FFFF; w_b = 64'd1; w_req_valid = 1'b1;
        @(posedge clk); #1;
        w_req_valid = 1'b0; w_a = '0; w_b = '0;
        while (!w_rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        vectors++;
        if (lat !== 4 || w_result !== 64'h0 || w_carry_out !== 1'b1) begin
            miscompares++;
            $display("FAIL wide_add: got lat=%0d r=%h c=%b want 4/0/1", lat, w_result, w_carry_out);
        end
        @(posedge clk); #1;
        w_sel = 3'b001; w_a = 64'd0; w_b = 64'd1; w_req_valid = 1'b1;
        @(posedge clk); #1;
        w_req_valid = 1'b0;
        lat = 1;
        while (!w_rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        vectors++;
        if (lat !== 4 || w_result !== 64'hFFFF_FFFF_FFFF_FFFF || w_carry_out !== 1'b0) begin
            miscompares++;
            $display("FAIL wide_sub: got lat=%0d r=%h c=%b want 4/ffffffffffffffff/0",
                     lat, w_result, w_carry_out);
        end
        @(posedge clk); #1;
        w_rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_slt();
        test_logic();
        test_hold();
        test_flush();
        test_illegal_reset();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
